sync_bd4_tx: RTL and testbench

- Clocked transmitter for the 4-phase bundled-data handshake used by the async latch pipelines.
- Accepts words from a synchronous valid/ready source and launches each one to an asynchronous receiver stage: `data` is held stable, `req` is raised, the receiver's `ack` is awaited, then the handshake returns to zero.
- `ack` arrives from the asynchronous side, so it is synchronized here.
- A one-entry input buffer lets the next word be accepted while a handshake is in flight.

---
 rtl/sync_bd4_tx.sv | 150 +++++++++++++++
 tb/tb_sync_bd4_tx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_bd4_tx.sv
`timescale 1ns/1ps
// sync_bd4_tx: clocked transmitter for a 4-phase bundled-data handshake.
// Takes words from a valid/ready source into a one-entry buffer and launches
// each one to an asynchronous receiver. The launch sequence is: drive data,
// wait SETUP cycles, raise req, wait for ack, drop req, wait for ack to fall.
// Ports:
//   clk, rst        clock and asynchronous active-low reset
//   in_valid/in_data/in_ready  synchronous source interface
//   req, data       bundled request/data to the receiver (registered)
//   ack             asynchronous acknowledge (synchronized internally)
//   busy            handshake in progress or buffer occupied
//   err             sticky: ack seen high while idle
module sync_bd4_tx #(
  parameter int unsigned N           = 8,
  parameter logic [N-1:0] Rval       = '0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SETUP       = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         req,
  output logic [N-1:0] data,
  input  logic         ack,
  output logic         busy,
  output logic         err
);

  localparam int unsigned CW = (SETUP > 1) ? $clog2(SETUP) : 1;

  typedef enum logic [2:0] {
    S_DRAIN,
    S_IDLE,
    S_SETUP,
    S_REQ_HI,
    S_REQ_LO
  } state_t;

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_vld;
  logic                   ack_s;
  logic                   sync_ok;
  logic [N-1:0]           buf_q, buf_nx;
  logic                   buf_full, buf_full_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic [N-1:0]           data_nx;
  logic                   req_nx;
  logic                   err_nx;
  logic                   accept;

  // ack synchronizer; sync_vld marks when the chain holds post-reset samples
  // so DRAIN does not mistake the cleared flops for a low ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      sync_vld <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], ack};
      sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign ack_s   = sync_q[SYNC_STAGES-1];
  assign sync_ok = sync_vld[SYNC_STAGES-1];
  assign accept  = in_valid & in_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_nx    = state;
    buf_nx      = buf_q;
    buf_full_nx = buf_full;
    cnt_nx      = cnt;
    data_nx     = data;
    req_nx      = req;
    err_nx      = err;

    // in_ready is low whenever the buffer is full, so accept never
    // coincides with the IDLE launch that empties the buffer.
    if (accept) begin
      buf_nx      = in_data;
      buf_full_nx = 1'b1;
    end

    case (state)
      S_DRAIN: begin
        if (sync_ok && !ack_s) state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (ack_s) begin
          err_nx = 1'b1;
        end else if (buf_full) begin
          data_nx     = buf_q;
          buf_full_nx = 1'b0;
          cnt_nx      = CW'(SETUP - 1);
          state_nx    = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          req_nx   = 1'b1;
          state_nx = S_REQ_HI;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_REQ_HI: begin
        if (ack_s) begin
          req_nx   = 1'b0;
          state_nx = S_REQ_LO;
        end
      end
      S_REQ_LO: begin
        if (!ack_s) state_nx = S_IDLE;
      end
      default: begin
        req_nx   = 1'b0;
        state_nx = S_DRAIN;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_DRAIN;
      buf_q    <= '0;
      buf_full <= 1'b0;
      cnt      <= '0;
      data     <= Rval;
      req      <= 1'b0;
      err      <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b1;
    end else begin
      state    <= state_nx;
      buf_q    <= buf_nx;
      buf_full <= buf_full_nx;
      cnt      <= cnt_nx;
      data     <= data_nx;
      req      <= req_nx;
      err      <= err_nx;
      in_ready <= !buf_full_nx;
      busy     <= (state_nx != S_IDLE) || buf_full_nx;
    end
  end

endmodule

// File: tb/tb_sync_bd4_tx.sv
`timescale 1ns/1ps
// Bench for sync_bd4_tx: two instances (SETUP=1 and SETUP=4) each with a
// source driver, a 4-phase receiver model and a scoreboard monitor.
module tb_sync_bd4_tx;

  localparam int unsigned N    = 8;
  localparam int unsigned SYNC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   mode;          // receiver: 0 auto, 1 ack forced high, 2 ack held low
  int   dmin, dmax;    // receiver response delay range (cycles)
  bit   rand_en;
  bit   err_allowed;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int unsigned SU = (g == 0) ? 1 : 4;

    logic         in_valid = 1'b0;
    logic [N-1:0] in_data  = '0;
    logic         in_ready, req, busy, err;
    logic         ack = 1'b0;
    logic [N-1:0] data;

    logic [N-1:0] push_q[$];
    logic [N-1:0] exp_q[$];

    // source state
    logic         rdy_last = 1'b0;
    logic [N-1:0] last_w   = '0;
    logic [N-1:0] w;
    // receiver state
    int           dly = -1;
    // monitor state
    logic         p_req = 1'b0, p_ack = 1'b0, p_rdy = 1'b0;
    logic [N-1:0] p_data = '0;
    logic [N-1:0] e;
    logic [N-1:0] last_launch = '0;
    int           since_data = 0, since_ack = 99;
    int           buf_cnt = 0, accepts = 0, launches = 0;

    sync_bd4_tx #(
      .N(N), .Rval('0), .SYNC_STAGES(SYNC), .SETUP(SU)
    ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .req(req), .data(data), .ack(ack),
      .busy(busy), .err(err)
    );

    // Source: directed words first, otherwise random words with bit 7 set,
    // always differing from the previous word so launches are observable.
    initial begin
      forever begin
        @(negedge clk); #2;
        if (!rst) begin
          in_valid = 1'b0;
          rdy_last = 1'b0;
        end else begin
          if (in_valid && rdy_last) in_valid = 1'b0;
          if (!in_valid) begin
            if (push_q.size() > 0) begin
              in_data  = push_q.pop_front();
              in_valid = 1'b1;
              last_w   = in_data;
            end else if (rand_en && $urandom_range(0, 3) != 0) begin
              do w = N'($urandom) | 8'h80; while (w == last_w);
              in_data  = w;
              in_valid = 1'b1;
              last_w   = w;
            end
          end
          rdy_last = in_ready;
        end
      end
    end

    // Receiver: follows req with ack after a random delay.
    initial begin
      forever begin
        @(negedge clk); #2;
        if (mode == 1) begin
          ack = 1'b1; dly = -1;
        end else if (mode == 2) begin
          ack = 1'b0; dly = -1;
        end else if (req != ack) begin
          if (dly < 0) dly = $urandom_range(dmax, dmin);
          if (dly == 0) begin
            ack = req; dly = -1;
          end else begin
            dly--;
          end
        end else begin
          dly = -1;
        end
      end
    end

    // Monitor: scoreboard of accepted words, popped on each req rise.
    initial begin
      forever begin
        @(negedge clk);
        if (!rst) begin
          chk($sformatf("u%0d rst_req", g), req, 0);
          chk($sformatf("u%0d rst_in_ready", g), in_ready, 0);
          exp_q.delete();
          buf_cnt   = 0;
          since_ack = 99;
          since_data = 0;
        end else begin
          if (in_valid && p_rdy) begin
            exp_q.push_back(in_data);
            buf_cnt++;
            accepts++;
          end
          if (data != p_data) begin
            chk($sformatf("u%0d launch_from_buf", g), buf_cnt > 0, 1);
            chk($sformatf("u%0d launch_req_low", g), {p_req, req}, 0);
            if (exp_q.size() > 0) chk($sformatf("u%0d launch_word", g), data, exp_q[0]);
            if (buf_cnt > 0) buf_cnt--;
            last_launch = data;
            since_data  = 0;
          end else begin
            since_data++;
          end
          chk($sformatf("u%0d in_ready", g), in_ready, buf_cnt == 0);
          if (buf_cnt > 0) chk($sformatf("u%0d busy", g), busy, 1);
          if (ack && !p_ack) since_ack = 0; else since_ack++;
          if (req && !p_req) begin
            chk($sformatf("u%0d req_setup_gap", g), since_data, SU);
            chk($sformatf("u%0d req_has_word", g), exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              chk($sformatf("u%0d req_data", g), data, e);
            end
            launches++;
          end
          if (!req && p_req) chk($sformatf("u%0d req_fall_lat", g), since_ack, SYNC);
          if (!err_allowed) chk($sformatf("u%0d err", g), err, 0);
        end
        p_req  = req;
        p_ack  = ack;
        p_rdy  = in_ready;
        p_data = data;
      end
    end
  end

  task automatic push(input logic [N-1:0] v);
    inst[0].push_q.push_back(v);
    inst[1].push_q.push_back(v);
  endtask

  task automatic wait_idle(input int maxc);
    bit done = 1'b0;
    for (int k = 0; k < maxc && !done; k++) begin
      @(negedge clk);
      done = !inst[0].busy && !inst[1].busy && !inst[0].req && !inst[1].req &&
             !inst[0].ack && !inst[1].ack && !inst[0].in_valid && !inst[1].in_valid &&
             inst[0].push_q.size() == 0 && inst[1].push_q.size() == 0;
    end
    chk("wait_idle_done", done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit up;
    rst = 1'b0; mode = 0; dmin = 1; dmax = 1; rand_en = 1'b0; err_allowed = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;

    // One edge after release.
    @(negedge clk);
    chk("u0 rel_in_ready", inst[0].in_ready, 1);
    chk("u1 rel_in_ready", inst[1].in_ready, 1);
    chk("u0 rel_req", inst[0].req, 0);
    chk("u1 rel_req", inst[1].req, 0);
    chk("u0 rel_data", inst[0].data, 8'h00);
    chk("u1 rel_data", inst[1].data, 8'h00);
    chk("u0 rel_err", inst[0].err, 0);
    chk("u1 rel_err", inst[1].err, 0);

    // Single word, fixed receiver delay.
    dmin = 3; dmax = 3;
    push(8'hA5);
    wait_idle(300);
    chk("u0 a5_launched", inst[0].last_launch, 8'hA5);
    chk("u1 a5_launched", inst[1].last_launch, 8'hA5);

    // Back-to-back words with a slow receiver.
    dmin = 8; dmax = 8;
    push(8'h11); push(8'h22); push(8'h33);
    wait_idle(600);
    chk("u0 b2b_last", inst[0].last_launch, 8'h33);
    chk("u1 b2b_last", inst[1].last_launch, 8'h33);

    // Random traffic and receiver delays.
    dmin = 0; dmax = 4; rand_en = 1'b1;
    repeat (800) @(negedge clk);
    rand_en = 1'b0;
    wait_idle(600);

    // Reset while in REQ_HI, ack held high across release.
    mode = 2;
    push(8'h5A);
    up = 1'b0;
    for (int k = 0; k < 200 && !up; k++) begin
      @(negedge clk);
      up = inst[0].req && inst[1].req;
    end
    chk("reqhi_reached", up, 1);
    @(negedge clk); #1;
    mode = 1; rst = 1'b0;
    #1;
    chk("u0 rst_req_async", inst[0].req, 0);
    chk("u1 rst_req_async", inst[1].req, 0);
    @(negedge clk); #1 rst = 1'b1;
    push(8'h3C);
    repeat (12) begin
      @(negedge clk);
      chk("u0 drain_req", inst[0].req, 0);
      chk("u1 drain_req", inst[1].req, 0);
      chk("u0 drain_data", inst[0].data, 8'h00);
      chk("u1 drain_data", inst[1].data, 8'h00);
    end
    dmin = 2; dmax = 2; mode = 0;
    wait_idle(300);
    chk("u0 post_rst_launch", inst[0].last_launch, 8'h3C);
    chk("u1 post_rst_launch", inst[1].last_launch, 8'h3C);

    // ack raised while idle sets the sticky error.
    err_allowed = 1'b1;
    @(negedge clk); #1 mode = 1;
    for (int k = 1; k <= SYNC + 1; k++) begin
      @(negedge clk);
      chk("u0 err_req", inst[0].req, 0);
      chk("u1 err_req", inst[1].req, 0);
      chk("u0 err_rise", inst[0].err, k == SYNC + 1);
      chk("u1 err_rise", inst[1].err, k == SYNC + 1);
    end
    mode = 0;
    repeat (10) begin
      @(negedge clk);
      chk("u0 err_sticky", inst[0].err, 1);
      chk("u1 err_sticky", inst[1].err, 1);
      chk("u0 err_noreq", inst[0].req, 0);
      chk("u1 err_noreq", inst[1].req, 0);
    end

    // Only reset clears err.
    #1 rst = 1'b0;
    @(negedge clk);
    chk("u0 err_clr", inst[0].err, 0);
    chk("u1 err_clr", inst[1].err, 0);
    err_allowed = 1'b0;
    #1 rst = 1'b1;
    repeat (8) @(negedge clk);

    chk("u0 all_launched", inst[0].launches, inst[0].accepts);
    chk("u1 all_launched", inst[1].launches, inst[1].accepts);
    chk("u0 sb_empty", inst[0].exp_q.size(), 0);
    chk("u1 sb_empty", inst[1].exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
